// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and backing-memory handshake signals of mem_port_arbiter.
// slave = arbiter view; master = stage/memory-model view.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      if_req;
    logic [ADDR_WIDTH-1:0]     if_addr;
    logic                      if_gnt;
    logic                      if_rvalid;
    logic [DATA_WIDTH-1:0]     if_rdata;

    logic                      dm_req;
    logic                      dm_we;
    logic [ADDR_WIDTH-1:0]     dm_addr;
    logic [DATA_WIDTH-1:0]     dm_wdata;
    logic [DATA_WIDTH/8-1:0]   dm_be;
    logic                      dm_gnt;
    logic                      dm_rvalid;
    logic [DATA_WIDTH-1:0]     dm_rdata;

    logic                      mem_req;
    logic                      mem_we;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic [DATA_WIDTH/8-1:0]   mem_be;
    logic                      mem_gnt;
    logic                      mem_rvalid;
    logic [DATA_WIDTH-1:0]     mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter in front of one single-ported memory; data has priority, a starvation
// counter forces fetch through. Define MEM_ARB_STATS_EN to add grant/conflict statistics.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_if_grants,
    output logic [31:0]       stat_dm_grants,
    output logic [31:0]       stat_conflicts
`endif
);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic [2:0] {IDLE, HOLD_IF, HOLD_DM, WAIT_IF, WAIT_DM} state_e;

    state_e                state_q, state_d;
    logic [7:0]            starve_q, starve_d;
    logic                  dm_we_q, dm_we_d;
    logic                  if_rvalid_q, if_rvalid_d;
    logic                  dm_rvalid_q, dm_rvalid_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;

    logic                  sel_if, sel_dm;
    logic                  if_hs, dm_hs;
    logic [ADDR_WIDTH-1:0] addr_mux;

    // Port selection: free choice in IDLE, locked in HOLD_x so a late requester cannot steal it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        sel_if = 1'b0;
        sel_dm = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.dm_req && !(bus.if_req && starve_q >= LIMIT)) sel_dm = 1'b1;
                else if (bus.if_req)                                  sel_if = 1'b1;
            end
            HOLD_IF: sel_if = 1'b1;
            HOLD_DM: sel_dm = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        addr_mux = '0;
        if (sel_dm)      addr_mux = bus.dm_addr;
        else if (sel_if) addr_mux = bus.if_addr;
    end

    assign if_hs         = sel_if & bus.mem_gnt;
    assign dm_hs         = sel_dm & bus.mem_gnt;

    assign bus.mem_req   = sel_if | sel_dm;
    assign bus.mem_we    = sel_dm & bus.dm_we;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = sel_dm ? bus.dm_wdata : '0;
    assign bus.mem_be    = sel_dm ? bus.dm_be : (sel_if ? '1 : '0);
    assign bus.if_gnt    = if_hs;
    assign bus.dm_gnt    = dm_hs;

    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rvalid = dm_rvalid_q;
    assign bus.dm_rdata  = dm_rdata_q;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        dm_we_d     = dm_we_q;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;

        case (state_q)
            IDLE, HOLD_IF, HOLD_DM: begin
                if (if_hs) begin
                    state_d = WAIT_IF;
                end else if (dm_hs) begin
                    state_d = WAIT_DM;
                    dm_we_d = bus.dm_we;
                end else if (sel_if) begin
                    state_d = HOLD_IF;
                end else if (sel_dm) begin
                    state_d = HOLD_DM;
                end
            end
            WAIT_IF: begin
                if (bus.mem_rvalid) begin
                    state_d     = IDLE;
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = bus.mem_rdata;
                end
            end
            WAIT_DM: begin
                if (bus.mem_rvalid) begin
                    state_d     = IDLE;
                    dm_rvalid_d = 1'b1;
                    dm_rdata_d  = dm_we_q ? '0 : bus.mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase

        // Data wins only while fetch waits count toward starvation.
        if (if_hs) begin
            starve_d = '0;
        end else if (dm_hs) begin
            if (!bus.if_req)          starve_d = '0;
            else if (starve_q < LIMIT) starve_d = starve_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking (<=) so all flops update from pre-edge values.
        if (!rst) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            dm_we_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            dm_we_q     <= dm_we_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_if_q, stat_if_d;
    logic [31:0] stat_dm_q, stat_dm_d;
    logic [31:0] stat_cf_q, stat_cf_d;

    always_comb begin
        stat_if_d = stat_if_q;
        stat_dm_d = stat_dm_q;
        stat_cf_d = stat_cf_q;
        if (if_hs && stat_if_q != '1) stat_if_d = stat_if_q + 32'd1;
        if (dm_hs && stat_dm_q != '1) stat_dm_d = stat_dm_q + 32'd1;
        if ((sel_if || sel_dm) && bus.if_req && bus.dm_req && stat_cf_q != '1)
            stat_cf_d = stat_cf_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_if_q <= '0;
            stat_dm_q <= '0;
            stat_cf_q <= '0;
        end else begin
            stat_if_q <= stat_if_d;
            stat_dm_q <= stat_dm_d;
            stat_cf_q <= stat_cf_d;
        end
    end

    assign stat_if_grants = stat_if_q;
    assign stat_dm_grants = stat_dm_q;
    assign stat_conflicts = stat_cf_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; the memory side is driven by hand
// so every handshake and response cycle is explicit.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_if_grants, stat_dm_grants, stat_conflicts;
`endif

    mem_port_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_if_grants(stat_if_grants),
        .stat_dm_grants(stat_dm_grants),
        .stat_conflicts(stat_conflicts)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.dm_req     = 1'b0;
        bus.dm_we      = 1'b0;
        bus.dm_addr    = '0;
        bus.dm_wdata   = '0;
        bus.dm_be      = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_mem_req"},   bus.mem_req,   1'b0);
        check({tag, "_if_gnt"},    bus.if_gnt,    1'b0);
        check({tag, "_dm_gnt"},    bus.dm_gnt,    1'b0);
        check({tag, "_if_rvalid"}, bus.if_rvalid, 1'b0);
        check({tag, "_dm_rvalid"}, bus.dm_rvalid, 1'b0);
        check({tag, "_if_rdata"},  bus.if_rdata,  32'h0);
        check({tag, "_dm_rdata"},  bus.dm_rdata,  32'h0);
    endtask

    logic exp_if;
    logic prev_if;

    initial begin
        quiet_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        rst = 1'b1;
        step();

        // Fetch-only read, immediate grant, response two cycles later.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_1000;
        bus.mem_gnt = 1'b1;
        #1;
        check("s1_if_gnt_c0", bus.if_gnt,   1'b1);
        check("s1_dm_gnt_c0", bus.dm_gnt,   1'b0);
        check("s1_mem_req",   bus.mem_req,  1'b1);
        check("s1_mem_addr",  bus.mem_addr, 32'h0000_1000);
        check("s1_mem_we",    bus.mem_we,   1'b0);
        check("s1_mem_be",    bus.mem_be,   4'hF);
        step();
        bus.if_req = 1'b0;
        #1;
        check("s1_wait_mem_req", bus.mem_req, 1'b0);
        check("s1_wait_if_gnt",  bus.if_gnt,  1'b0);
        step();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0000_0013;
        #1;
        check("s1_if_rvalid_c2", bus.if_rvalid, 1'b0);
        step();
        bus.mem_rvalid = 1'b0;
        #1;
        check("s1_if_rvalid_c3", bus.if_rvalid, 1'b1);
        check("s1_if_rdata_c3",  bus.if_rdata,  32'h0000_0013);
        check("s1_dm_rvalid_c3", bus.dm_rvalid, 1'b0);
        step();
        check("s1_if_rvalid_c4", bus.if_rvalid, 1'b0);

        // Data write: response data must come back as zero.
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 32'h0000_0100;
        bus.dm_wdata = 32'hDEAD_BEEF;
        bus.dm_be    = 4'b0011;
        #1;
        check("s3_dm_gnt",    bus.dm_gnt,    1'b1);
        check("s3_mem_we",    bus.mem_we,    1'b1);
        check("s3_mem_be",    bus.mem_be,    4'b0011);
        check("s3_mem_addr",  bus.mem_addr,  32'h0000_0100);
        check("s3_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        step();
        bus.dm_req     = 1'b0;
        bus.dm_we      = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFF_FFFF;
        step();
        bus.mem_rvalid = 1'b0;
        #1;
        check("s3_dm_rvalid", bus.dm_rvalid, 1'b1);
        check("s3_dm_rdata",  bus.dm_rdata,  32'h0);
        check("s3_if_rvalid", bus.if_rvalid, 1'b0);
        step();

        // Fetch locked in HOLD_IF while memory stalls; data request arrives late.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_2000;
        bus.mem_gnt = 1'b0;
        #1;
        check("s4_c0_mem_req",  bus.mem_req,  1'b1);
        check("s4_c0_mem_addr", bus.mem_addr, 32'h0000_2000);
        check("s4_c0_if_gnt",   bus.if_gnt,   1'b0);
        step();
        bus.dm_req  = 1'b1;
        bus.dm_addr = 32'h0000_0300;
        for (int c = 1; c < 3; c++) begin
            #1;
            check($sformatf("s4_c%0d_mem_addr", c), bus.mem_addr, 32'h0000_2000);
            check($sformatf("s4_c%0d_dm_gnt", c),   bus.dm_gnt,   1'b0);
            step();
        end
        bus.mem_gnt = 1'b1;
        #1;
        check("s4_c3_if_gnt", bus.if_gnt, 1'b1);
        check("s4_c3_dm_gnt", bus.dm_gnt, 1'b0);
        step();
        bus.if_req = 1'b0;
        #1;
        check("s4_wait_dm_gnt",  bus.dm_gnt,  1'b0);
        check("s4_wait_mem_req", bus.mem_req, 1'b0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0000_0055;
        step();
        bus.mem_rvalid = 1'b0;
        #1;
        check("s4_if_rvalid",  bus.if_rvalid, 1'b1);
        check("s4_if_rdata",   bus.if_rdata,  32'h0000_0055);
        check("s4_dm_gnt",     bus.dm_gnt,    1'b1);
        check("s4_dm_addr",    bus.mem_addr,  32'h0000_0300);
        step();
        bus.dm_req     = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0000_0066;
        step();
        bus.mem_rvalid = 1'b0;
        #1;
        check("s4_dm_rvalid", bus.dm_rvalid, 1'b1);
        check("s4_dm_rdata",  bus.dm_rdata,  32'h0000_0066);
        step();

        // Reset while a data read is outstanding; the late response must be dropped.
        bus.dm_req  = 1'b1;
        bus.dm_addr = 32'h0000_0500;
        #1;
        check("s5_dm_gnt", bus.dm_gnt, 1'b1);
        step();
        bus.dm_req = 1'b0;
        rst        = 1'b0;
        step();
        rst            = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0000_0077;
        step();
        bus.mem_rvalid = 1'b0;
        #1;
        check_quiet("s5_after_reset");
        step();

        // Both ports request continuously: four data grants, then one fetch grant.
        prev_if = 1'b0;
        for (int g = 0; g < 10; g++) begin
            bus.if_req     = 1'b1;
            bus.if_addr    = 32'h0000_3000 + 32'(g * 4);
            bus.dm_req     = 1'b1;
            bus.dm_we      = 1'b0;
            bus.dm_addr    = 32'h0000_0400 + 32'(g * 4);
            bus.mem_gnt    = 1'b1;
            bus.mem_rvalid = 1'b0;
            #1;
            exp_if = (g == 4) || (g == 9);
            check($sformatf("s2_g%0d_if_gnt", g), bus.if_gnt, exp_if);
            check($sformatf("s2_g%0d_dm_gnt", g), bus.dm_gnt, !exp_if);
            if (g > 0) begin
                check($sformatf("s2_g%0d_prev_if_rvalid", g), bus.if_rvalid, prev_if);
                check($sformatf("s2_g%0d_prev_dm_rvalid", g), bus.dm_rvalid, !prev_if);
            end
            prev_if = exp_if;
            step();
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'hA000_0000 + 32'(g);
            step();
        end
        quiet_inputs();
        #1;
        check("s2_last_if_rvalid", bus.if_rvalid, 1'b1);
        check("s2_last_if_rdata",  bus.if_rdata,  32'hA000_0009);
`ifdef MEM_ARB_STATS_EN
        check("stat_dm_grants", stat_dm_grants, 32'd8);
        check("stat_if_grants", stat_if_grants, 32'd2);
        check("stat_conflicts", stat_conflicts, 32'd10);
`endif
        step();

        // Stray response with nothing outstanding is ignored.
        bus.mem_rvalid = 1'b1;
        step();
        bus.mem_rvalid = 1'b0;
        #1;
        check("stray_if_rvalid", bus.if_rvalid, 1'b0);
        check("stray_dm_rvalid", bus.dm_rvalid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported backing memory between the fetch stage (read-only instruction port) and the MEM stage (read/write data port).
- Grants one transaction at a time with req/gnt/rvalid handshakes and supports variable memory latency.
- Data port has priority; a starvation counter guarantees fetch forward progress.
- Sits between fetch/mem stage logic and the unified memory model.

Parameters:
- ADDR_WIDTH, 32, byte address width on all ports
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits before fetch is forced first; legal range 1..255

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request; held with if_addr until if_gnt
- if_addr  in  ADDR_WIDTH  fetch address
- if_gnt  out  1  fetch request accepted by memory this cycle
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_WIDTH  fetch read data
- dm_req  in  1  data request; held with all dm_* fields until dm_gnt
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  write data
- dm_be  in  DATA_WIDTH/8  byte enables
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  one-cycle pulse: read data valid, or write completed
- dm_rdata  out  DATA_WIDTH  data read data; 0 on write completion
- mem_req  out  1  request to memory
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_be  out  DATA_WIDTH/8  memory byte enables; all ones for fetch
- mem_gnt  in  1  memory accepts request (mem_req & mem_gnt = handshake)
- mem_rvalid  in  1  response valid, for both reads and writes; at least 1 cycle after handshake
- mem_rdata  in  DATA_WIDTH  memory read data

Behaviour:
- States: IDLE, HOLD_IF, HOLD_DM, WAIT_IF, WAIT_DM. Reset enters IDLE; starve_cnt = 0.
- Registered outputs reset to 0: if_rvalid, dm_rvalid, if_rdata, dm_rdata.
- Combinational outputs are 0 whenever the state is not IDLE or HOLD_x.
- IDLE selection:
  - dm_req only, or both requesting with starve_cnt < STARVE_LIMIT → data port.
  - if_req only, or both requesting with starve_cnt == STARVE_LIMIT → fetch port.
  - Neither requesting → mem_req = 0.
- While a port is selected in IDLE/HOLD_x:
  - mem_req = 1; mem_* is muxed from the selected port; mem_we = 0 for fetch.
  - x_gnt = mem_gnt, combinational, same cycle.
- Transitions:
  - IDLE with handshake → WAIT_x.
  - IDLE without mem_gnt → HOLD_x. The selection is locked: a later request on the other port never steals it.
  - HOLD_x with mem_gnt → WAIT_x.
- WAIT_x: mem_req = 0, both gnt = 0.
  - On mem_rvalid: the next cycle x_rvalid = 1 with x_rdata = mem_rdata (dm_rdata = 0 for writes); state → IDLE.
  - Latency from mem_rvalid to x_rvalid is 1 cycle. A new arbitration can occur in the same cycle x_rvalid pulses.
- Only one transaction is outstanding at a time.
- starve_cnt is updated at each handshake:
  - Data grant while if_req = 1 → increment, saturating at STARVE_LIMIT.
  - Fetch grant → clear.
  - Data grant while if_req = 0 → clear.
- Boundary conditions:
  - mem_rvalid in IDLE or HOLD_x is ignored; no rvalid is produced.
  - Reset mid-transaction aborts to IDLE and any late response is dropped.
  - A requester dropping its req in HOLD_x is a protocol violation; the arbiter keeps driving mem_req until mem_gnt.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- Defined: adds outputs stat_if_grants, stat_dm_grants, stat_conflicts, each 32 bits, reset to 0, saturating at all ones.
  - stat_if_grants and stat_dm_grants increment once per handshake on the respective port.
  - stat_conflicts increments every cycle where if_req & dm_req in IDLE/HOLD_x.
- Not defined: these ports and counters do not exist. Arbitration behaviour is identical either way.

Test Plan:
- Fetch-only read, mem_gnt immediate, mem_rvalid 2 cycles later with 0x00000013 → if_gnt in cycle 0, if_rvalid in cycle 3 with if_rdata = 0x00000013, dm_rvalid never asserts.
- Both request continuously with mem_gnt = 1 and 1-cycle response latency, STARVE_LIMIT = 4 → grant order DM, DM, DM, DM, IF, DM, DM, DM, DM, IF…
- Data write dm_addr = 0x100, dm_wdata = 0xDEADBEEF, dm_be = 4'b0011 → mem_we = 1, mem_be = 4'b0011; dm_rvalid pulses with dm_rdata = 0.
- Fetch selected with mem_gnt held low 3 cycles, dm_req rises in cycle 1 → mem_addr stays at if_addr, if_gnt in cycle 3, dm_gnt only after if_rvalid.
- rst low in WAIT_DM, then mem_rvalid after release → state IDLE, no dm_rvalid, all outputs 0.
- With MEM_ARB_STATS_EN, the scenario 2 run for 10 grants → stat_dm_grants = 8, stat_if_grants = 2, stat_conflicts > 0.
